// File: rtl/alu_issue_unit.sv
// Fetch/issue sequencer: fetches one word at a time, hands it to the ALU and
// computes the next pc from the branch opcode and the ALU's zero flag.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_IDLE     | out of reset, waiting for start
//   S_FETCH    | imem_req high for one cycle at imem_addr = pc
//   S_WAIT_MEM | waiting for imem_rvalid; word captured into instr
//   S_ISSUE    | instr_valid high, instr held until alu_ready
//   S_WAIT_ALU | waiting for alu_done; next pc resolved from alu_flags
//   S_HALT     | halt word fetched; pc/instr/issued_cnt frozen until start
module alu_issue_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        alu_ready,
  input  logic        alu_done,
  input  logic [2:0]  alu_flags,
  output logic [31:0] pc,
  output logic [15:0] issued_cnt,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_ISSUE,
    S_WAIT_ALU,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] cnt_q, cnt_d;

  logic [5:0]  opcode;
  logic        branch_taken;
  logic [31:0] branch_off;
  logic [31:0] pc_seq;
  logic        flags_unused;

  // Only the zero flag steers control flow.
  assign flags_unused = ^alu_flags[2:1];

  assign opcode       = instr_q[31:26];
  assign branch_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign pc_seq       = pc_q + 32'd4;
  assign branch_taken = ((opcode == OP_BEQ) &&  alu_flags[0]) ||
                        ((opcode == OP_BNE) && !alu_flags[0]);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          cnt_d   = 16'd0;
        end
      end
      S_FETCH: state_d = S_WAIT_MEM;
      S_WAIT_MEM: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = (imem_rdata == HALT_WORD) ? S_HALT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // alu_done in this cycle belongs to no instruction and is dropped.
        if (alu_ready) begin
          state_d = S_WAIT_ALU;
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
      end
      S_WAIT_ALU: begin
        if (alu_done) begin
          state_d = S_FETCH;
          pc_d    = branch_taken ? (pc_seq + branch_off) : pc_seq;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign pc          = pc_q;
  assign issued_cnt  = cnt_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: byte address of the first instruction fetched after start.
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF: instruction word that stops issue.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk input 1, rising-edge clock for all state.
REQ-004 SHALL have rst_n input 1: asynchronous active-low reset.
REQ-005 SHALL have start input 1: one-cycle pulse that begins fetching at RESET_PC; ignored unless in IDLE or HALT.
REQ-006 SHALL have imem_req output 1: fetch request, valid for exactly one cycle per fetch.
REQ-007 SHALL have imem_addr output 32: fetch byte address, equal to pc.
REQ-008 SHALL have imem_rvalid input 1: fetched word valid, arriving 1 or more cycles after imem_req.
REQ-009 SHALL have imem_rdata input 32: fetched instruction word.
REQ-010 SHALL have instr output 32: instruction presented to the ALU.
REQ-011 SHALL have instr_valid output 1: instr is valid and held stable until accepted.
REQ-012 SHALL have alu_ready input 1: ALU accepts instr when instr_valid && alu_ready.
REQ-013 SHALL have alu_done input 1: ALU result and flags valid, for one cycle.
REQ-014 SHALL have alu_flags input 3: [0] zero, [1] negative, [2] overflow.
REQ-015 SHALL have pc output 32: address of the current instruction.
REQ-016 SHALL have issued_cnt output 16: count of accepted instructions, saturating at 16'hFFFF.
REQ-017 SHALL have busy output 1: high in every state except IDLE and HALT.
REQ-018 SHALL have halted output 1: high in HALT.

Function
REQ-019 SHALL implement states IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_ALU, and HALT.
REQ-020 SHALL move from IDLE or HALT to FETCH on start, loading pc=RESET_PC and clearing issued_cnt.
REQ-021 SHALL, in FETCH, assert imem_req for one cycle and then move to WAIT_MEM.
REQ-022 SHALL, in WAIT_MEM with imem_rvalid, register imem_rdata into instr and then go to HALT if the word equals HALT_WORD, otherwise to ISSUE.
REQ-023 SHALL, in ISSUE, hold instr_valid high with instr unchanged until alu_ready, then increment issued_cnt and move to WAIT_ALU; instr_valid SHALL drop the cycle after acceptance.
REQ-024 SHALL, in WAIT_ALU with alu_done, compute next pc and return to FETCH.
REQ-025 SHALL, for opcode instr[31:26]=6'b000100 (beq), branch when alu_flags[0]=1.
REQ-026 SHALL, for opcode 6'b000101 (bne), branch when alu_flags[0]=0.
REQ-027 SHALL set next pc on a branch to pc+4+(sign-extended instr[15:0] << 2); all other cases use pc+4.
REQ-028 SHALL compute pc arithmetic modulo 2^32: wrap-around is silent and no flag is raised.
REQ-029 SHALL use a minimum fetch-to-fetch latency of 4 cycles (FETCH, WAIT_MEM, ISSUE, WAIT_ALU) when imem_rvalid, alu_ready, and alu_done each arrive in the earliest cycle.
REQ-030 SHALL ignore alu_done outside WAIT_ALU and imem_rvalid outside WAIT_MEM.
REQ-031 SHALL ignore start while busy.
REQ-032 SHALL, when alu_ready and alu_done are both high in ISSUE, accept the instruction and ignore that alu_done.
REQ-033 SHALL hold pc, instr, and issued_cnt in HALT; halted stays high until the next start.

Reset
REQ-034 SHALL, on rst_n low at any time including mid-fetch or mid-issue, immediately enter IDLE with imem_req=0, instr_valid=0, instr=0, pc=RESET_PC, imem_addr=RESET_PC, issued_cnt=0, busy=0, halted=0.
REQ-035 SHALL ignore any imem_rvalid or alu_done returned after reset until a new start.

Verification
REQ-036 Scenario: start; memory returns add word 32'h0001_0020 one cycle after the request, then 32'hFFFF_FFFF; alu_ready and alu_done are immediate -> imem_addr 0 then 4, issued_cnt=1, halted=1, pc=4.
REQ-037 Scenario: beq 32'h1001_FFFF at pc=8 with alu_flags=3'b001 -> next imem_addr=8 (self-loop); the same word with flags 3'b000 -> imem_addr=12.
REQ-038 Scenario: bne 32'h1401_0003 at pc=0 with zero flag 0 -> next imem_addr=16.
REQ-039 Scenario: alu_ready held low for 5 cycles in ISSUE -> instr_valid stays high, instr is stable, and issued_cnt increments once.
REQ-040 Scenario: rst_n pulsed low while in WAIT_MEM, then imem_rvalid arrives -> state IDLE, instr_valid=0, and the late data is ignored.
REQ-041 Scenario: pc=32'hFFFF_FFFC with a non-branch -> next imem_addr=32'h0000_0000.
